// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one word read at a time, hands words to decode. Optional IFU_PERF_EN adds perf counters.
// Latency: request in N accepted, response in N+1, inst_valid in N+2; 3 cycles per instruction back to back.
// Backpressure: holds inst/inst_pc stable until inst_ready; mem_req_valid stays high until mem_req_ready.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            capture;
  logic [XLEN-1:0] redir_pc;
  logic            unused_redir_lsb;

  assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    capture = 1'b0;
    if (halt_req) begin
      state_n = S_HALT;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_REQ;
          if (redirect_valid) pc_n = redir_pc;
        end
        S_REQ: begin
          if (redirect_valid) pc_n = redir_pc;
          // An accepted request already carries the old pc, so its response must be dropped.
          if (mem_req_ready) begin
            state_n = S_WAIT;
            kill_n  = redirect_valid;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_n = redir_pc;
            if (mem_resp_valid) begin
              state_n = S_REQ;
              kill_n  = 1'b0;
            end else begin
              kill_n = 1'b1;
            end
          end else if (mem_resp_valid) begin
            if (kill) begin
              kill_n  = 1'b0;
              state_n = S_REQ;
            end else begin
              capture = 1'b1;
              state_n = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_n    = redir_pc;
            state_n = S_REQ;
          end else if (inst_ready) begin
            pc_n    = pc + XLEN'(4);
            state_n = S_REQ;
          end
        end
        S_HALT: state_n = S_HALT;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      if (capture) begin
        inst    <= mem_resp_data;
        inst_pc <= pc;
      end
    end
  end

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = pc;
  assign inst_valid    = (state == S_HOLD);
  assign halted        = (state == S_HALT);

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if ((state == S_WAIT) || (state == S_REQ && !mem_req_ready))
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule
